modexp_ctrl: RTL
================

Name: modexp_ctrl

Overview:
- Initiator for the Montgomery product unit: sequences left-to-right binary modular exponentiation X = M^E mod N as a series of MonPro requests.
- Drives the MonPro start/ready/valid handshake from the requester side and captures each result.
- Applies the final conditional subtraction itself, because MonPro returns values in [0, 2N).
- Sits between the top-level RSA core and one shared MonPro instance.

Parameters:
- DATAWIDTH, 64, operand/modulus width; must match the attached MonPro.
- E_WIDTH, 64, exponent width in bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while ready=1.
- ready  out  1  high in IDLE only.
- o_valid  out  1  one-cycle result pulse.
- i_M  in  DATAWIDTH  base; requires M < N.
- i_E  in  E_WIDTH  exponent.
- i_N  in  DATAWIDTH  odd modulus; requires 4N < 2^DATAWIDTH.
- i_R2  in  DATAWIDTH  R^2 mod N, with R = 2^DATAWIDTH.
- o_result  out  DATAWIDTH  M^E mod N, fully reduced.
- mp_start  out  1  MonPro start.
- mp_ready  in  1  MonPro ready.
- mp_valid  in  1  MonPro o_valid (single-cycle pulse).
- mp_A  out  DATAWIDTH  MonPro operand A.
- mp_B  out  DATAWIDTH  MonPro operand B.
- mp_N  out  DATAWIDTH  MonPro modulus.
- mp_U  in  DATAWIDTH  MonPro result; valid only in the mp_valid cycle.

Behaviour:
- Reset values: ready=1 (state IDLE); o_valid=0, o_result=0, mp_start=0, mp_A=0, mp_B=0, mp_N=0. Bit counter and all internal registers 0.
- Reset is asynchronous and effective at any time, including mid-operation. mp_start deasserts immediately. A MonPro pulse from an aborted operation is ignored, because the controller is in IDLE.
- Latch on start: in IDLE with start=1, latch M, E, N, R2; clear bit counter to E_WIDTH-1. start is ignored outside IDLE.
- States: IDLE -> PRE_M -> PRE_R -> (SQUARE -> [MULT]) loop -> POST -> REDUCE -> DONE -> IDLE.
  - PRE_M: Mb = MonPro(M, R2).
  - PRE_R: Xb = MonPro(1, R2), which equals R mod N.
  - SQUARE: Xb = MonPro(Xb, Xb). Then go to MULT if E[cnt]=1; otherwise decrement cnt.
  - MULT: Xb = MonPro(Mb, Xb), then decrement cnt.
  - The loop exits to POST after processing bit 0; cnt does not wrap.
  - POST: X = MonPro(Xb, 1).
  - REDUCE: one cycle; o_result <= (X >= N) ? X-N : X, compared at DATAWIDTH+1 bits.
  - DONE: o_valid=1 for one cycle, then IDLE.
- MonPro sub-handshake inside each MonPro state:
  - Phase ISSUE: drive mp_A, mp_B, mp_N registered; assert mp_start=1 for exactly one cycle when mp_ready=1. If mp_ready=0, hold and wait.
  - Phase WAIT: mp_start=0; operands held stable.
  - On the mp_valid cycle: capture mp_U and advance.
  - mp_valid outside WAIT is ignored.
- Intermediate Xb and Mb are kept unreduced in [0, 2N).
- o_result holds until the next start latch.
- Edge cases:
  - E=0: result 1.
  - M=0, E>0: result 0.
  - N=1: result 0.
- MonPro request count: 3 + E_WIDTH + popcount(E).

Optional Feature:
- MODEXP_SKIP_LEADING_ZEROS_EN.
- Defined:
  - On start latch, cnt loads the index of the most significant 1 of E.
  - If E=0, go directly PRE_R -> POST.
  - Request count becomes 3 + (msb_index+1) + popcount(E), or 2 for E=0.
- Undefined: all E_WIDTH bits are processed, as described in Behaviour.
- o_result is identical either way.

Decomposition:
- modexp_pkg holds:
  - typedef enum modexp_state_t (IDLE, PRE_M, PRE_R, SQUARE, MULT, POST, REDUCE, DONE);
  - typedef enum mp_phase_t (ISSUE, WAIT);
  - the localparam for the literal-one operand.
- MonPro is not instantiated inside; it stays external so it can be shared and swapped.
- One natural sub-module, used only when the macro is defined: modexp_msb_detect, a combinational priority encoder on E.

Test Plan:
- DATAWIDTH=8, E_WIDTH=8, N=61, R2=22, M=5, E=3 -> o_result=3. Exactly 3+8+2=13 mp_start pulses (without macro). One o_valid pulse.
- Same N/R2, M=2, E=10 -> 48. With macro defined -> 48 using 3+4+2=9 requests.
- E=0, M=17 -> 1. M=0, E=7 -> 0.
- MonPro model with mp_ready held low 5 cycles and randomized 1-20 cycle latency:
  - mp_start never asserted while mp_ready=0;
  - mp_A, mp_B, mp_N stable from issue until mp_valid;
  - correct results.
- Assert rst during the SQUARE WAIT phase, then the stale mp_valid arrives -> ready=1, o_valid stays 0. Then M=5, E=3 -> 3.
- start asserted mid-operation -> ignored. Back-to-back starts on the ready cycle after DONE -> both results correct.

Source files
------------

// File: rtl/modexp_pkg.sv
// ============================================================================
// Module      : modexp_pkg
// Description : Shared types and constants for the modular exponentiation
//               controller (state encodings, MonPro phase, literal-one operand)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package modexp_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRE_M  = 3'd1,
    PRE_R  = 3'd2,
    SQUARE = 3'd3,
    MULT   = 3'd4,
    POST   = 3'd5,
    REDUCE = 3'd6,
    DONE   = 3'd7
  } modexp_state_t;

  typedef enum logic [0:0] {
    ISSUE = 1'b0,
    WAIT  = 1'b1
  } mp_phase_t;

  localparam int unsigned c_MP_ONE = 1;

endpackage

`default_nettype wire

// File: rtl/modexp_msb_detect.sv
// ============================================================================
// Module      : modexp_msb_detect
// Description : Combinational priority encoder returning the index of the
//               most significant set bit of the exponent (0 when E is zero)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module modexp_msb_detect #(
  parameter int E_WIDTH = 64,
  parameter int CNT_W   = 6
) (
  input  logic [E_WIDTH-1:0] i_E,
  output logic [CNT_W-1:0]   o_idx
);

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < E_WIDTH; i++) begin
      if (i_E[i]) begin
        o_idx = CNT_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/modexp_ctrl.sv
// ============================================================================
// Module      : modexp_ctrl
// Description : Left-to-right binary modular exponentiation sequencer driving
//               an external Montgomery product (MonPro) unit.
//               Optional macro: MODEXP_SKIP_LEADING_ZEROS_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module modexp_ctrl
  import modexp_pkg::*;
#(
  parameter int DATAWIDTH = 64,
  parameter int E_WIDTH   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 ready,
  output logic                 o_valid,
  input  logic [DATAWIDTH-1:0] i_M,
  input  logic [E_WIDTH-1:0]   i_E,
  input  logic [DATAWIDTH-1:0] i_N,
  input  logic [DATAWIDTH-1:0] i_R2,
  output logic [DATAWIDTH-1:0] o_result,
  output logic                 mp_start,
  input  logic                 mp_ready,
  input  logic                 mp_valid,
  output logic [DATAWIDTH-1:0] mp_A,
  output logic [DATAWIDTH-1:0] mp_B,
  output logic [DATAWIDTH-1:0] mp_N,
  input  logic [DATAWIDTH-1:0] mp_U
);

  localparam int                   c_CNT_W   = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;
  localparam logic [DATAWIDTH-1:0] c_ONE     = DATAWIDTH'(c_MP_ONE);
  localparam logic [c_CNT_W-1:0]   c_CNT_TOP = c_CNT_W'(E_WIDTH - 1);

  modexp_state_t        r_state, w_state_nx;
  mp_phase_t            r_phase, w_phase_nx;

  logic [E_WIDTH-1:0]   r_E;
  logic [DATAWIDTH-1:0] r_R2;
  logic [DATAWIDTH-1:0] r_Mb;
  logic [DATAWIDTH-1:0] r_Xb;
  logic [DATAWIDTH-1:0] r_X;
  logic [DATAWIDTH-1:0] r_result;
  logic [DATAWIDTH-1:0] r_mp_A, r_mp_B, r_mp_N;
  logic [c_CNT_W-1:0]   r_cnt;

  logic                 w_in_mp;
  logic                 w_mp_start;
  logic                 w_capture;
  logic                 w_cnt_dec;
  logic                 w_latch;
  logic                 w_load_ops;
  logic [c_CNT_W-1:0]   w_cnt_init;
  logic                 w_e0_in;
  logic                 w_e0_lat;
  logic [DATAWIDTH-1:0] w_xb_nx;
  logic [DATAWIDTH-1:0] w_ld_A, w_ld_B;
  logic [DATAWIDTH:0]   w_diff;
  logic                 w_ge;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  logic [c_CNT_W-1:0] w_msb_idx;

  modexp_msb_detect #(
    .E_WIDTH (E_WIDTH),
    .CNT_W   (c_CNT_W)
  ) u_msb_detect (
    .i_E   (i_E),
    .o_idx (w_msb_idx)
  );

  assign w_cnt_init = w_msb_idx;
  assign w_e0_in    = ~|i_E;
  assign w_e0_lat   = ~|r_E;
`else
  assign w_cnt_init = c_CNT_TOP;
  assign w_e0_in    = 1'b0;
  assign w_e0_lat   = 1'b0;
`endif

  assign w_latch = (r_state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_phase <= ISSUE;
    end else begin
      r_state <= w_state_nx;
      r_phase <= w_phase_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_phase_nx = r_phase;
    w_mp_start = 1'b0;
    w_capture  = 1'b0;
    w_cnt_dec  = 1'b0;
    w_in_mp    = r_state inside {PRE_M, PRE_R, SQUARE, MULT, POST};

    if (w_in_mp) begin
      if (r_phase == ISSUE) begin
        if (mp_ready) begin
          w_mp_start = 1'b1;
          w_phase_nx = WAIT;
        end
      end else if (mp_valid) begin
        w_capture  = 1'b1;
        w_phase_nx = ISSUE;
      end
    end

    case (r_state)
      IDLE:   if (start) w_state_nx = w_e0_in ? PRE_R : PRE_M;
      PRE_M:  if (w_capture) w_state_nx = PRE_R;
      PRE_R:  if (w_capture) w_state_nx = w_e0_lat ? POST : SQUARE;
      SQUARE: begin
        if (w_capture) begin
          if (r_E[r_cnt]) begin
            w_state_nx = MULT;
          end else begin
            w_cnt_dec  = (r_cnt != '0);
            w_state_nx = (r_cnt == '0) ? POST : SQUARE;
          end
        end
      end
      MULT: begin
        if (w_capture) begin
          w_cnt_dec  = (r_cnt != '0);
          w_state_nx = (r_cnt == '0) ? POST : SQUARE;
        end
      end
      POST:   if (w_capture) w_state_nx = REDUCE;
      REDUCE: w_state_nx = DONE;
      DONE:   w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // Operands for the next request are registered in the same cycle the
  // previous result is captured, so the freshly arriving mp_U is forwarded.
  assign w_load_ops = w_capture || w_latch;

  always_comb begin
    w_xb_nx = (w_capture && (r_state inside {PRE_R, SQUARE, MULT})) ? mp_U : r_Xb;
    w_ld_A  = r_mp_A;
    w_ld_B  = r_mp_B;
    case (w_state_nx)
      PRE_M: begin
        w_ld_A = i_M;
        w_ld_B = i_R2;
      end
      PRE_R: begin
        w_ld_A = c_ONE;
        w_ld_B = (r_state == IDLE) ? i_R2 : r_R2;
      end
      SQUARE: begin
        w_ld_A = w_xb_nx;
        w_ld_B = w_xb_nx;
      end
      MULT: begin
        w_ld_A = r_Mb;
        w_ld_B = w_xb_nx;
      end
      POST: begin
        w_ld_A = w_xb_nx;
        w_ld_B = c_ONE;
      end
      default: begin
        w_ld_A = r_mp_A;
        w_ld_B = r_mp_B;
      end
    endcase
  end

  assign w_diff = {1'b0, r_X} - {1'b0, r_mp_N};
  assign w_ge   = ~w_diff[DATAWIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_E      <= '0;
      r_R2     <= '0;
      r_Mb     <= '0;
      r_Xb     <= '0;
      r_X      <= '0;
      r_result <= '0;
      r_mp_A   <= '0;
      r_mp_B   <= '0;
      r_mp_N   <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_latch) begin
        r_E    <= i_E;
        r_R2   <= i_R2;
        r_mp_N <= i_N;
        r_cnt  <= w_cnt_init;
      end
      if (w_cnt_dec) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture) begin
        case (r_state)
          PRE_M:               r_Mb <= mp_U;
          PRE_R, SQUARE, MULT: r_Xb <= mp_U;
          POST:                r_X  <= mp_U;
          default:             ;
        endcase
      end
      if (w_load_ops) begin
        r_mp_A <= w_ld_A;
        r_mp_B <= w_ld_B;
      end
      if (r_state == REDUCE) begin
        r_result <= w_ge ? w_diff[DATAWIDTH-1:0] : r_X;
      end
    end
  end

  assign ready    = (r_state == IDLE);
  assign o_valid  = (r_state == DONE);
  assign o_result = r_result;
  assign mp_start = w_mp_start;
  assign mp_A     = r_mp_A;
  assign mp_B     = r_mp_B;
  assign mp_N     = r_mp_N;

endmodule

`default_nettype wire
